// File: rtl/dbg_mem_arb.sv
// Arbitrates one 16-bit single-port RAM between the CPU bus and a one-entry debug slot.
// CPU has priority; a pending debug access wins after MAXWAIT losses or immediately under halt.
module dbg_mem_arb #(
  parameter int AW      = 16,
  parameter int MAXWAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          halt,
  input  logic          dbg_cs,
  input  logic          dbg_rd,
  input  logic [1:0]    dbg_wr,
  input  logic [AW-1:0] dbg_addr,
  input  logic [15:0]   dbg_wdata,
  output logic [15:0]   dbg_rdata,
  output logic          dbg_rvalid,
  output logic          dbg_busy,
  output logic          dbg_ovf,
  input  logic          cpu_cs,
  input  logic          cpu_rd,
  input  logic [1:0]    cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [15:0]   cpu_wdata,
  output logic [15:0]   cpu_rdata,
  output logic          cpu_ready,
  output logic          mem_cs,
  output logic [1:0]    mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  input  logic [15:0]   mem_rdata
);

  localparam int WCW = $clog2(MAXWAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAXWAIT);

  typedef struct packed {
    logic          rd;
    logic [1:0]    wr;
    logic [AW-1:0] addr;
    logic [15:0]   wdata;
  } dbg_req_t;

  dbg_req_t       slot_q, slot_d;
  logic           pend_q, pend_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic           rd_dbg_q, rd_dbg_d;
  logic [15:0]    rdata_q, rdata_d;
  logic           rvalid_q, rvalid_d;
  logic           ovf_q, ovf_d;
  logic           gnt_dbg, gnt_cpu;

  // The RAM has no read strobe: a select with zero byte enables is a read.
  logic unused_cpu_rd;
  assign unused_cpu_rd = cpu_rd;

  always_comb begin
    gnt_dbg = ~reset & pend_q & (halt | ~cpu_cs | (wait_q == WAIT_MAX));
    gnt_cpu = ~reset & cpu_cs & ~halt & ~gnt_dbg;
  end

  always_comb begin
    slot_d   = slot_q;
    pend_d   = pend_q;
    ovf_d    = ovf_q;
    wait_d   = wait_q;
    rd_dbg_d = gnt_dbg & slot_q.rd;
    rvalid_d = rd_dbg_q;
    rdata_d  = rd_dbg_q ? mem_rdata : rdata_q;

    if (gnt_dbg) begin
      pend_d = 1'b0;
    end
    // A slot being granted this cycle can be reloaded in the same cycle.
    if (dbg_cs) begin
      if (!pend_q || gnt_dbg) begin
        pend_d        = 1'b1;
        slot_d.rd     = dbg_rd;
        slot_d.wr     = dbg_wr;
        slot_d.addr   = dbg_addr;
        slot_d.wdata  = dbg_wdata;
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (!pend_q || gnt_dbg) begin
      wait_d = '0;
    end else if (gnt_cpu && (wait_q != WAIT_MAX)) begin
      wait_d = wait_q + WCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q   <= '0;
      pend_q   <= 1'b0;
      wait_q   <= '0;
      rd_dbg_q <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      pend_q   <= pend_d;
      wait_q   <= wait_d;
      rd_dbg_q <= rd_dbg_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    mem_cs    = gnt_dbg | gnt_cpu;
    mem_wr    = 2'b00;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (gnt_dbg) begin
      mem_wr    = slot_q.wr;
      mem_addr  = slot_q.addr;
      mem_wdata = slot_q.wdata;
    end else if (gnt_cpu) begin
      mem_wr    = cpu_wr;
    end
  end

  assign cpu_ready  = gnt_cpu;
  assign cpu_rdata  = mem_rdata;
  assign dbg_rdata  = rdata_q;
  assign dbg_rvalid = rvalid_q;
  assign dbg_busy   = pend_q;
  assign dbg_ovf    = ovf_q;

endmodule

// File: tb/tb_dbg_mem_arb.sv
// Directed bench for dbg_mem_arb with a 1-cycle-latency RAM model; MAXWAIT = 4.
module tb_dbg_mem_arb;

  logic        clk;
  logic        reset, halt;
  logic        dbg_cs, dbg_rd;
  logic [1:0]  dbg_wr;
  logic [15:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        dbg_rvalid, dbg_busy, dbg_ovf;
  logic        cpu_cs, cpu_rd;
  logic [1:0]  cpu_wr;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic        mem_cs;
  logic [1:0]  mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] ram [0:255];

  dbg_mem_arb #(.AW(16), .MAXWAIT(4)) dut (
    .clk(clk), .reset(reset), .halt(halt),
    .dbg_cs(dbg_cs), .dbg_rd(dbg_rd), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .dbg_busy(dbg_busy), .dbg_ovf(dbg_ovf),
    .cpu_cs(cpu_cs), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_cs(mem_cs), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: preset words reloaded on reset, read-before-write, 1-cycle read latency.
  always @(posedge clk) begin
    if (reset) begin
      ram[8'h08] <= 16'hBEEF;
      ram[8'h10] <= 16'h1234;
      ram[8'h20] <= 16'h0000;
      ram[8'h80] <= 16'h7777;
    end else if (mem_cs) begin
      mem_rdata <= ram[mem_addr[8:1]];
      if (mem_wr[0]) ram[mem_addr[8:1]][7:0]  <= mem_wdata[7:0];
      if (mem_wr[1]) ram[mem_addr[8:1]][15:8] <= mem_wdata[15:8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    dbg_cs = 1'b0;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic dbg(input logic rd, input logic [1:0] wr, input logic [15:0] a,
                     input logic [15:0] d);
    dbg_cs = 1'b1; dbg_rd = rd; dbg_wr = wr; dbg_addr = a; dbg_wdata = d;
  endtask

  initial begin
    reset = 1'b1; halt = 1'b0;
    dbg_cs = 1'b0; dbg_rd = 1'b0; dbg_wr = 2'b00; dbg_addr = '0; dbg_wdata = '0;
    cpu_cs = 1'b1; cpu_rd = 1'b1; cpu_wr = 2'b00; cpu_addr = 16'h0100; cpu_wdata = '0;

    // reset cycle: no grant even with a CPU request
    smp();
    check("rst_mem_cs", mem_cs, 0);
    check("rst_cpu_ready", cpu_ready, 0);
    nxt(); reset = 1'b0; cpu_cs = 1'b0;
    smp();
    check("rst_rdata", dbg_rdata, 0);
    check("rst_rvalid", dbg_rvalid, 0);
    check("rst_busy", dbg_busy, 0);
    check("rst_ovf", dbg_ovf, 0);

    // 1: idle CPU, debug read of 0x0010
    nxt(); dbg(1'b1, 2'b00, 16'h0010, 16'h0000);
    smp(); check("t1_busy_T", dbg_busy, 0);
    check("t1_memcs_T", mem_cs, 0);
    nxt(); smp();
    check("t1_memcs_T1", mem_cs, 1);
    check("t1_addr_T1", mem_addr, 16'h0010);
    check("t1_wr_T1", mem_wr, 0);
    check("t1_busy_T1", dbg_busy, 1);
    nxt(); smp(); check("t1_rvalid_T2", dbg_rvalid, 0);
    nxt(); smp();
    check("t1_rvalid_T3", dbg_rvalid, 1);
    check("t1_rdata_T3", dbg_rdata, 16'hBEEF);
    nxt(); smp(); check("t1_rvalid_T4", dbg_rvalid, 0);

    // 2: CPU saturating, debug lo-lane write waits MAXWAIT cycles
    nxt(); cpu_cs = 1'b1; cpu_addr = 16'h0100;
    dbg(1'b0, 2'b01, 16'h0021, 16'h005A);
    smp(); check("t2_rdy_T", cpu_ready, 1);
    for (int i = 1; i <= 4; i++) begin
      nxt(); smp();
      check($sformatf("t2_rdy_T%0d", i), cpu_ready, 1);
      check($sformatf("t2_addr_T%0d", i), mem_addr, 16'h0100);
      if (i == 1) check("t2_cpu_rdata", cpu_rdata, 16'h7777);
    end
    nxt(); smp();
    check("t2_rdy_gnt", cpu_ready, 0);
    check("t2_memcs_gnt", mem_cs, 1);
    check("t2_wr_gnt", mem_wr, 2'b01);
    check("t2_addr_gnt", mem_addr, 16'h0021);
    check("t2_wdata_gnt", mem_wdata, 16'h005A);
    nxt(); smp();
    check("t2_rdy_resume", cpu_ready, 1);
    check("t2_busy_free", dbg_busy, 0);
    check("t2_ram_word", ram[8'h10], 16'h125A);
    check("t2_dbg_rdata_hold", dbg_rdata, 16'hBEEF);
    check("t2_no_rvalid", dbg_rvalid, 0);

    // 3: halt with CPU request held; debug served at minimum latency
    nxt(); halt = 1'b1; dbg(1'b1, 2'b00, 16'h0010, 16'h0000);
    smp(); check("t3_rdy_T", cpu_ready, 0);
    nxt(); smp();
    check("t3_memcs_T1", mem_cs, 1);
    check("t3_addr_T1", mem_addr, 16'h0010);
    check("t3_rdy_T1", cpu_ready, 0);
    nxt(); smp();
    nxt(); smp();
    check("t3_rvalid_T3", dbg_rvalid, 1);
    check("t3_rdata_T3", dbg_rdata, 16'hBEEF);
    nxt(); dbg(1'b0, 2'b11, 16'h0030, 16'hCAFE);
    smp();
    nxt(); smp();
    check("t3_wr_gnt", mem_wr, 2'b11);
    check("t3_waddr_gnt", mem_addr, 16'h0030);
    check("t3_wrdy", cpu_ready, 0);
    nxt(); dbg(1'b1, 2'b00, 16'h0030, 16'h0000);
    smp();
    nxt(); smp(); check("t3_rd2_memcs", mem_cs, 1);
    nxt(); smp();
    nxt(); smp();
    check("t3_rd2_rvalid", dbg_rvalid, 1);
    check("t3_rd2_rdata", dbg_rdata, 16'hCAFE);
    check("t3_rd2_rdy", cpu_ready, 0);
    nxt(); halt = 1'b0;
    smp(); check("t3_cpu_resume", cpu_ready, 1);

    // 5: reload of the slot in its own grant cycle
    nxt(); cpu_cs = 1'b0; dbg(1'b0, 2'b11, 16'h0050, 16'h1111);
    smp();
    nxt(); dbg(1'b1, 2'b00, 16'h0050, 16'h0000);
    smp();
    check("t5_w_memcs", mem_cs, 1);
    check("t5_w_wr", mem_wr, 2'b11);
    check("t5_w_addr", mem_addr, 16'h0050);
    check("t5_w_wdata", mem_wdata, 16'h1111);
    nxt(); smp();
    check("t5_r_memcs", mem_cs, 1);
    check("t5_r_wr", mem_wr, 2'b00);
    check("t5_r_addr", mem_addr, 16'h0050);
    check("t5_ovf", dbg_ovf, 0);
    nxt(); smp(); check("t5_busy", dbg_busy, 0);
    nxt(); smp();
    check("t5_rvalid", dbg_rvalid, 1);
    check("t5_rdata", dbg_rdata, 16'h1111);
    check("t5_ovf_end", dbg_ovf, 0);

    // 4: second dbg_cs dropped while the CPU holds the bus
    nxt(); cpu_cs = 1'b1; cpu_addr = 16'h0100; dbg(1'b1, 2'b00, 16'h0010, 16'h0000);
    smp();
    nxt(); dbg(1'b0, 2'b11, 16'h0040, 16'hDEAD);
    smp();
    check("t4_rdy_T1", cpu_ready, 1);
    check("t4_busy_T1", dbg_busy, 1);
    nxt(); smp(); check("t4_ovf_T2", dbg_ovf, 1);
    nxt(); smp();
    nxt(); smp(); check("t4_rdy_T4", cpu_ready, 1);
    nxt(); smp();
    check("t4_rdy_gnt", cpu_ready, 0);
    check("t4_addr_gnt", mem_addr, 16'h0010);
    check("t4_wr_gnt", mem_wr, 2'b00);
    nxt(); smp();
    nxt(); smp();
    check("t4_rvalid", dbg_rvalid, 1);
    check("t4_rdata", dbg_rdata, 16'hBEEF);
    check("t4_ovf_sticky", dbg_ovf, 1);
    nxt(); cpu_cs = 1'b0;
    smp();
    check("t4_dropped_ram", ram[8'h20], 16'h0000);
    check("t4_ovf_sticky2", dbg_ovf, 1);

    // 6: reset one cycle after a debug read grant
    nxt(); dbg(1'b1, 2'b00, 16'h0010, 16'h0000);
    smp();
    nxt(); smp(); check("t6_gnt", mem_cs, 1);
    nxt(); reset = 1'b1; cpu_cs = 1'b1;
    smp();
    check("t6_rst_memcs", mem_cs, 0);
    check("t6_rst_rdy", cpu_ready, 0);
    check("t6_rst_wr", mem_wr, 0);
    nxt(); reset = 1'b0; cpu_cs = 1'b0;
    smp();
    check("t6_rvalid", dbg_rvalid, 0);
    check("t6_rdata", dbg_rdata, 0);
    check("t6_busy", dbg_busy, 0);
    check("t6_ovf", dbg_ovf, 0);
    check("t6_memcs", mem_cs, 0);
    nxt(); smp(); check("t6_rvalid2", dbg_rvalid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
